opb_master_bridge: RTL and testbench

- OPB bus master: turns single-word commands from user (fabric) logic into OPB read/write transfers toward OPB slaves such as the simulink2ppc/ppc2simulink software registers and BRAMs.
- Initiator-side counterpart of the OPB slave register cores: requests the bus, arbitrates, drives address and data, and handles xferAck/errAck/retry/timeout.
- Returns read data and completion status on a response handshake.
- Sits in the OPB clock domain beside the PPC master on the shared OPB.

---
 rtl/opb_master_bridge.sv | 221 ++++++++++++++++++++++
 tb/tb_opb_master_bridge.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opb_master_bridge.sv
// opb_master_bridge: single-word OPB bus master. Takes read/write commands
// from fabric logic, requests the bus, runs one OPB transfer (handling
// xferAck / errAck / retry / local timeout) and returns data plus status on
// a response handshake.
// Optional build macro: OPB_MASTER_STATS_EN adds saturating ok/error
// response counters (stat_ok, stat_err) with a synchronous clear (stat_clr).
module opb_master_bridge #(
  parameter int C_OPB_AWIDTH     = 32,
  parameter int C_OPB_DWIDTH     = 32,
  parameter int C_TIMEOUT_CYCLES = 16,
  parameter int C_MAX_RETRY      = 8
) (
  input  logic                        OPB_Clk,
  input  logic                        OPB_Rst_n,
  // user command
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_rnw,
  input  logic [0:C_OPB_AWIDTH-1]     cmd_addr,
  input  logic [0:C_OPB_DWIDTH/8-1]   cmd_be,
  input  logic [0:C_OPB_DWIDTH-1]     cmd_wdata,
  // user response
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [0:C_OPB_DWIDTH-1]     rsp_rdata,
  output logic [1:0]                  rsp_status,
  // OPB master side
  output logic                        M_request,
  output logic                        M_busLock,
  output logic                        M_select,
  output logic                        M_RNW,
  output logic [0:C_OPB_DWIDTH/8-1]   M_BE,
  output logic                        M_seqAddr,
  output logic [0:C_OPB_AWIDTH-1]     M_ABus,
  output logic [0:C_OPB_DWIDTH-1]     M_DBus,
  input  logic                        OPB_MGrant,
  input  logic                        OPB_xferAck,
  input  logic                        OPB_errAck,
  input  logic                        OPB_retry,
  input  logic                        OPB_toutSup,
  input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus
`ifdef OPB_MASTER_STATS_EN
  ,
  input  logic                        stat_clr,
  output logic [15:0]                 stat_ok,
  output logic [15:0]                 stat_err
`endif
);

  localparam int BEW = C_OPB_DWIDTH / 8;
  localparam int TW  = $clog2(C_TIMEOUT_CYCLES + 1);
  localparam int RW  = $clog2(C_MAX_RETRY + 1);
  localparam logic [TW-1:0] TOUT_LAST = TW'(C_TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(C_MAX_RETRY);

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_ERR   = 2'b01;
  localparam logic [1:0] ST_TOUT  = 2'b10;
  localparam logic [1:0] ST_RETRY = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_RESP} state_e;

  state_e                 state_q, state_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   rnw_q, rnw_d;
  logic [0:C_OPB_AWIDTH-1] addr_q, addr_d;
  logic [0:BEW-1]         be_q, be_d;
  logic [0:C_OPB_DWIDTH-1] wdata_q, wdata_d;
  logic [0:C_OPB_DWIDTH-1] rdata_q, rdata_d;
  logic [1:0]             status_q, status_d;
  logic [TW-1:0]          tout_q, tout_d;
  logic [RW-1:0]          retry_q, retry_d;
  logic [RW-1:0]          retry_inc;

  // Next-state, command capture, counters and response bookkeeping
  always_comb begin
    state_d   = state_q;
    rnw_d     = rnw_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    status_d  = status_q;
    tout_d    = tout_q;
    retry_d   = retry_q;
    retry_inc = retry_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          rnw_d    = cmd_rnw;
          addr_d   = cmd_addr;
          be_d     = cmd_be;
          wdata_d  = cmd_wdata;
          rdata_d  = '0;
          status_d = ST_OK;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        // a grant that goes away before we sample it just keeps us asking
        if (OPB_MGrant) state_d = S_XFER;
      end
      S_XFER: begin
        if (OPB_errAck) begin
          status_d = ST_ERR;
          rdata_d  = '0;
          state_d  = S_RESP;
        end else if (OPB_xferAck) begin
          status_d = ST_OK;
          if (rnw_q) rdata_d = OPB_DBus;
          state_d  = S_RESP;
        end else if (OPB_retry) begin
          retry_d = retry_inc;
          // each re-arbitrated attempt gets a fresh timeout window
          tout_d  = '0;
          if (retry_inc == RETRY_MAX) begin
            status_d = ST_RETRY;
            state_d  = S_RESP;
          end else begin
            state_d  = S_REQ;
          end
        end else if (!OPB_toutSup) begin
          if (tout_q == TOUT_LAST) begin
            status_d = ST_TOUT;
            state_d  = S_RESP;
          end else begin
            tout_d = tout_q + 1'b1;
          end
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          tout_d  = '0;
          retry_d = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // registered so it stays low in reset and rises one cycle after the
    // response handshake, never overlapping with rsp_valid
    cmd_ready_d = (state_d == S_IDLE);
  end

  // State and datapath registers
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      rnw_q       <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      status_q    <= ST_OK;
      tout_q      <= '0;
      retry_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rnw_q       <= rnw_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      status_q    <= status_d;
      tout_q      <= tout_d;
      retry_q     <= retry_d;
    end
  end

  // Outputs decode straight from state flops, so reset clears them at once;
  // bus fields are zero when not selected so they can be OR-ed on the OPB.
  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_rdata  = rsp_valid ? rdata_q : '0;
  assign rsp_status = rsp_valid ? status_q : 2'b00;
  assign M_request  = (state_q == S_REQ);
  assign M_select   = (state_q == S_XFER);
  assign M_busLock  = 1'b0;
  assign M_seqAddr  = 1'b0;
  assign M_RNW      = M_select & rnw_q;
  assign M_BE       = M_select ? be_q : '0;
  assign M_ABus     = M_select ? addr_q : '0;
  assign M_DBus     = (M_select && !rnw_q) ? wdata_q : '0;

`ifdef OPB_MASTER_STATS_EN
  logic [15:0] stat_ok_q, stat_ok_d, stat_err_q, stat_err_d;

  // Saturating response counters; clear wins over a same-cycle increment
  always_comb begin
    stat_ok_d  = stat_ok_q;
    stat_err_d = stat_err_q;
    if (stat_clr) begin
      stat_ok_d  = '0;
      stat_err_d = '0;
    end else if (rsp_valid && rsp_ready) begin
      if (status_q == ST_OK) begin
        if (stat_ok_q != 16'hFFFF) stat_ok_d = stat_ok_q + 16'd1;
      end else begin
        if (stat_err_q != 16'hFFFF) stat_err_d = stat_err_q + 16'd1;
      end
    end
  end

  // Statistics registers
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      stat_ok_q  <= '0;
      stat_err_q <= '0;
    end else begin
      stat_ok_q  <= stat_ok_d;
      stat_err_q <= stat_err_d;
    end
  end

  assign stat_ok  = stat_ok_q;
  assign stat_err = stat_err_q;
`endif

endmodule

// File: tb/tb_opb_master_bridge.sv
// Directed testbench for opb_master_bridge. A second instance built with
// C_MAX_RETRY=2 covers the retry-limit case; stats checks follow the macro.
module tb_opb_master_bridge;

  logic        OPB_Clk, OPB_Rst_n;
  logic        cmd_valid, cmd_ready, cmd_rnw;
  logic [0:31] cmd_addr, cmd_wdata;
  logic [0:3]  cmd_be;
  logic        rsp_valid, rsp_ready;
  logic [0:31] rsp_rdata;
  logic [1:0]  rsp_status;
  logic        M_request, M_busLock, M_select, M_RNW, M_seqAddr;
  logic [0:3]  M_BE;
  logic [0:31] M_ABus, M_DBus;
  logic        OPB_MGrant, OPB_xferAck, OPB_errAck, OPB_retry, OPB_toutSup;
  logic [0:31] OPB_DBus;
`ifdef OPB_MASTER_STATS_EN
  logic        stat_clr;
  logic [15:0] stat_ok, stat_err;
`endif

  // second instance (retry limit 2)
  logic        cmd_valid2, r2_cmd_ready, r2_rsp_valid, rsp_ready2;
  logic [0:31] r2_rsp_rdata;
  logic [1:0]  r2_rsp_status;
  logic        r2_M_request, r2_M_busLock, r2_M_select, r2_M_RNW, r2_M_seqAddr;
  logic [0:3]  r2_M_BE;
  logic [0:31] r2_M_ABus, r2_M_DBus;
`ifdef OPB_MASTER_STATS_EN
  logic [15:0] r2_stat_ok, r2_stat_err;
`endif

  int total = 0;
  int bad   = 0;

  opb_master_bridge dut (
    .OPB_Clk(OPB_Clk), .OPB_Rst_n(OPB_Rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
    .cmd_addr(cmd_addr), .cmd_be(cmd_be), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_status(rsp_status),
    .M_request(M_request), .M_busLock(M_busLock), .M_select(M_select),
    .M_RNW(M_RNW), .M_BE(M_BE), .M_seqAddr(M_seqAddr), .M_ABus(M_ABus),
    .M_DBus(M_DBus), .OPB_MGrant(OPB_MGrant), .OPB_xferAck(OPB_xferAck),
    .OPB_errAck(OPB_errAck), .OPB_retry(OPB_retry),
    .OPB_toutSup(OPB_toutSup), .OPB_DBus(OPB_DBus)
`ifdef OPB_MASTER_STATS_EN
    , .stat_clr(stat_clr), .stat_ok(stat_ok), .stat_err(stat_err)
`endif
  );

  opb_master_bridge #(.C_MAX_RETRY(2)) dut_r2 (
    .OPB_Clk(OPB_Clk), .OPB_Rst_n(OPB_Rst_n),
    .cmd_valid(cmd_valid2), .cmd_ready(r2_cmd_ready), .cmd_rnw(cmd_rnw),
    .cmd_addr(cmd_addr), .cmd_be(cmd_be), .cmd_wdata(cmd_wdata),
    .rsp_valid(r2_rsp_valid), .rsp_ready(rsp_ready2), .rsp_rdata(r2_rsp_rdata),
    .rsp_status(r2_rsp_status),
    .M_request(r2_M_request), .M_busLock(r2_M_busLock), .M_select(r2_M_select),
    .M_RNW(r2_M_RNW), .M_BE(r2_M_BE), .M_seqAddr(r2_M_seqAddr),
    .M_ABus(r2_M_ABus), .M_DBus(r2_M_DBus), .OPB_MGrant(OPB_MGrant),
    .OPB_xferAck(OPB_xferAck), .OPB_errAck(OPB_errAck), .OPB_retry(OPB_retry),
    .OPB_toutSup(OPB_toutSup), .OPB_DBus(OPB_DBus)
`ifdef OPB_MASTER_STATS_EN
    , .stat_clr(stat_clr), .stat_ok(r2_stat_ok), .stat_err(r2_stat_err)
`endif
  );

  initial OPB_Clk = 1'b0;
  always #5 OPB_Clk = ~OPB_Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic tick();
    @(posedge OPB_Clk);
    #1;
  endtask

  // present a command and wait (bounded) until it is accepted; leaves us in REQ
  task automatic issue(input logic rnw, input logic [31:0] a,
                       input logic [3:0] be, input logic [31:0] wd);
    int n;
    n = 0;
    cmd_rnw = rnw; cmd_addr = a; cmd_be = be; cmd_wdata = wd;
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 20) begin tick(); n++; end
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL issue_ready got=%0b exp=1", cmd_ready); end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    OPB_Rst_n = 1'b0;
    cmd_valid = 0; cmd_valid2 = 0; cmd_rnw = 0; cmd_addr = 0; cmd_be = 0;
    cmd_wdata = 0; rsp_ready = 0; rsp_ready2 = 0; OPB_MGrant = 1;
    OPB_xferAck = 0; OPB_errAck = 0; OPB_retry = 0; OPB_toutSup = 0; OPB_DBus = 0;
`ifdef OPB_MASTER_STATS_EN
    stat_clr = 0;
`endif
    #12;
    total++;
    if ({cmd_ready, rsp_valid, M_request, M_select, M_RNW, M_busLock, M_seqAddr} !== 7'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=0000000",
        {cmd_ready, rsp_valid, M_request, M_select, M_RNW, M_busLock, M_seqAddr});
    end
    total++;
    if (M_ABus !== 32'h0 || M_DBus !== 32'h0 || M_BE !== 4'h0) begin
      bad++; $display("FAIL reset_bus got=%h/%h/%h exp=0", M_ABus, M_DBus, M_BE);
    end
    @(posedge OPB_Clk); #1;
    OPB_Rst_n = 1'b1;
    tick();
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", cmd_ready); end
  endtask

  task automatic test_write();
    issue(1'b0, 32'h01000300, 4'hF, 32'hDEADBEEF);
    total++;
    if (M_request !== 1'b1 || M_select !== 1'b0 || cmd_ready !== 1'b0 || M_ABus !== 32'h0) begin
      bad++; $display("FAIL wr_req got=req%0b sel%0b rdy%0b a=%h exp=req1 sel0 rdy0 a=0",
        M_request, M_select, cmd_ready, M_ABus);
    end
    tick();
    total++;
    if (M_select !== 1'b1 || M_request !== 1'b0 || M_RNW !== 1'b0 || M_BE !== 4'hF ||
        M_ABus !== 32'h01000300 || M_DBus !== 32'hDEADBEEF) begin
      bad++; $display("FAIL wr_xfer got=sel%0b req%0b rnw%0b be%h a=%h d=%h exp=sel1 req0 rnw0 beF a=01000300 d=DEADBEEF",
        M_select, M_request, M_RNW, M_BE, M_ABus, M_DBus);
    end
    OPB_xferAck = 1'b1;
    tick();
    OPB_xferAck = 1'b0;
    // third cycle after acceptance
    total++;
    if (rsp_valid !== 1'b1 || rsp_status !== 2'b00 || rsp_rdata !== 32'h0) begin
      bad++; $display("FAIL wr_rsp got=v%0b st%b d=%h exp=v1 st00 d=0", rsp_valid, rsp_status, rsp_rdata);
    end
    total++;
    if (M_select !== 1'b0 || M_ABus !== 32'h0 || M_DBus !== 32'h0) begin
      bad++; $display("FAIL wr_busdrop got=sel%0b a=%h d=%h exp=0", M_select, M_ABus, M_DBus);
    end
    drain();
    total++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL wr_done got=v%0b rdy%0b exp=v0 rdy1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_read_hold();
    issue(1'b1, 32'h01000300, 4'hF, 32'hCAFEF00D);
    tick();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (M_select !== 1'b1 || M_RNW !== 1'b1 || M_DBus !== 32'h0 || M_ABus !== 32'h01000300) begin
        bad++; $display("FAIL rd_sel%0d got=sel%0b rnw%0b d=%h a=%h exp=sel1 rnw1 d=0 a=01000300",
          i, M_select, M_RNW, M_DBus, M_ABus);
      end
      if (i == 2) begin OPB_xferAck = 1'b1; OPB_DBus = 32'h12345678; end
      else OPB_DBus = 32'hFFFFFFFF;
      tick();
    end
    OPB_xferAck = 1'b0; OPB_DBus = 32'h0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h12345678 || rsp_status !== 2'b00) begin
        bad++; $display("FAIL rd_hold%0d got=v%0b d=%h st%b exp=v1 d=12345678 st00",
          i, rsp_valid, rsp_rdata, rsp_status);
      end
      tick();
    end
    drain();
    total++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL rd_done got=v%0b rdy%0b exp=v0 rdy1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_retry();
    issue(1'b0, 32'h00000010, 4'h3, 32'h0000ABCD);
    tick();
    for (int i = 0; i < 2; i++) begin
      OPB_retry = 1'b1;
      tick();
      OPB_retry = 1'b0;
      total++;
      if (M_request !== 1'b1 || M_select !== 1'b0) begin
        bad++; $display("FAIL retry_rereq%0d got=req%0b sel%0b exp=req1 sel0", i, M_request, M_select);
      end
      tick();
    end
    total++;
    if (M_select !== 1'b1 || M_BE !== 4'h3) begin
      bad++; $display("FAIL retry_sel got=sel%0b be%h exp=sel1 be3", M_select, M_BE);
    end
    OPB_xferAck = 1'b1;
    tick();
    OPB_xferAck = 1'b0;
    total++;
    if (rsp_valid !== 1'b1 || rsp_status !== 2'b00) begin
      bad++; $display("FAIL retry_ok got=v%0b st%b exp=v1 st00", rsp_valid, rsp_status);
    end
    drain();
  endtask

  task automatic test_retry_limit();
    cmd_rnw = 1'b1; cmd_addr = 32'h00000020; cmd_be = 4'hF; cmd_wdata = 32'h0;
    cmd_valid2 = 1'b1;
    tick();
    cmd_valid2 = 1'b0;
    tick();
    OPB_retry = 1'b1;
    tick();
    tick();
    tick();
    OPB_retry = 1'b0;
    total++;
    if (r2_rsp_valid !== 1'b1 || r2_rsp_status !== 2'b11 || r2_rsp_rdata !== 32'h0) begin
      bad++; $display("FAIL retry_limit got=v%0b st%b d=%h exp=v1 st11 d=0",
        r2_rsp_valid, r2_rsp_status, r2_rsp_rdata);
    end
    total++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL retry_limit_main got=v%0b rdy%0b exp=v0 rdy1", rsp_valid, cmd_ready);
    end
    rsp_ready2 = 1'b1;
    tick();
    rsp_ready2 = 1'b0;
  endtask

  task automatic test_timeout();
    int n;
    issue(1'b1, 32'h00000040, 4'hF, 32'h0);
    tick();
    n = 0;
    while (M_select === 1'b1 && n < 40) begin n++; tick(); end
    total++;
    if (n != 16) begin bad++; $display("FAIL tout_cycles got=%0d exp=16", n); end
    total++;
    if (rsp_valid !== 1'b1 || rsp_status !== 2'b10 || rsp_rdata !== 32'h0) begin
      bad++; $display("FAIL tout_rsp got=v%0b st%b d=%h exp=v1 st10 d=0", rsp_valid, rsp_status, rsp_rdata);
    end
    drain();
    // suppressed timeout: 20 select cycles then ack
    issue(1'b1, 32'h00000044, 4'hF, 32'h0);
    OPB_toutSup = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) tick();
    total++;
    if (M_select !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL toutsup_hold got=sel%0b v%0b exp=sel1 v0", M_select, rsp_valid);
    end
    OPB_xferAck = 1'b1; OPB_toutSup = 1'b0; OPB_DBus = 32'h0BADF00D;
    tick();
    OPB_xferAck = 1'b0; OPB_DBus = 32'h0;
    total++;
    if (rsp_valid !== 1'b1 || rsp_status !== 2'b00 || rsp_rdata !== 32'h0BADF00D) begin
      bad++; $display("FAIL toutsup_rsp got=v%0b st%b d=%h exp=v1 st00 d=0BADF00D",
        rsp_valid, rsp_status, rsp_rdata);
    end
    drain();
  endtask

  task automatic test_errack();
    issue(1'b1, 32'h00000080, 4'hF, 32'h0);
    tick();
    OPB_errAck = 1'b1; OPB_xferAck = 1'b1; OPB_DBus = 32'hA5A5A5A5;
    tick();
    OPB_errAck = 1'b0; OPB_xferAck = 1'b0; OPB_DBus = 32'h0;
    total++;
    if (rsp_valid !== 1'b1 || rsp_status !== 2'b01 || rsp_rdata !== 32'h0) begin
      bad++; $display("FAIL errack got=v%0b st%b d=%h exp=v1 st01 d=0", rsp_valid, rsp_status, rsp_rdata);
    end
    drain();
  endtask

  task automatic test_grant_wait();
    OPB_MGrant = 1'b0;
    issue(1'b0, 32'h00000100, 4'h1, 32'h00000055);
    tick(); tick(); tick();
    total++;
    if (M_request !== 1'b1 || M_select !== 1'b0) begin
      bad++; $display("FAIL grant_wait got=req%0b sel%0b exp=req1 sel0", M_request, M_select);
    end
    OPB_MGrant = 1'b1;
    tick();
    total++;
    if (M_select !== 1'b1 || M_DBus !== 32'h00000055) begin
      bad++; $display("FAIL grant_sel got=sel%0b d=%h exp=sel1 d=00000055", M_select, M_DBus);
    end
    OPB_xferAck = 1'b1;
    tick();
    OPB_xferAck = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid();
    int seen;
    issue(1'b0, 32'h00000200, 4'hF, 32'h11112222);
    tick();
    #2 OPB_Rst_n = 1'b0;
    #1;
    total++;
    if (M_select !== 1'b0 || M_request !== 1'b0 || M_ABus !== 32'h0 || M_DBus !== 32'h0) begin
      bad++; $display("FAIL rstmid_drop got=sel%0b req%0b a=%h d=%h exp=0", M_select, M_request, M_ABus, M_DBus);
    end
    @(posedge OPB_Clk); #1;
    OPB_Rst_n = 1'b1;
    tick();
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%0b exp=1", cmd_ready); end
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      OPB_xferAck = 1'b1;
      if (rsp_valid === 1'b1) seen++;
      tick();
    end
    OPB_xferAck = 1'b0;
    total++;
    if (seen != 0) begin bad++; $display("FAIL rstmid_norsp got=%0d exp=0", seen); end
  endtask

`ifdef OPB_MASTER_STATS_EN
  task automatic test_stats();
    stat_clr = 1'b1; tick(); stat_clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 32'h00000300, 4'hF, 32'h0);
      tick();
      if (i == 3) OPB_errAck = 1'b1; else OPB_xferAck = 1'b1;
      tick();
      OPB_errAck = 1'b0; OPB_xferAck = 1'b0;
      drain();
    end
    total++;
    if (stat_ok !== 16'd3 || stat_err !== 16'd1) begin
      bad++; $display("FAIL stats_count got=ok%0d err%0d exp=ok3 err1", stat_ok, stat_err);
    end
    stat_clr = 1'b1; tick(); stat_clr = 1'b0;
    total++;
    if (stat_ok !== 16'd0 || stat_err !== 16'd0) begin
      bad++; $display("FAIL stats_clr got=ok%0d err%0d exp=0", stat_ok, stat_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read_hold();
    test_retry();
    test_retry_limit();
    test_timeout();
    test_errack();
    test_grant_wait();
    test_reset_mid();
`ifdef OPB_MASTER_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
